// File: rtl/mmio_uart_tx_if.sv
// CPU data-memory side of the MMIO UART transmitter: store strobe, address,
// store data and the combinational hit/read-data return path.
interface mmio_uart_tx_if;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        hit;
  logic [31:0] rdata;

  modport master (output we, addr, wdata, input  hit, rdata);
  modport slave  (input  we, addr, wdata, output hit, rdata);
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: byte FIFO feeding an 8N1 serialiser.
// Define MMIO_UART_TX_PARITY_EN to insert an even-parity bit (8E1).
module mmio_uart_tx #(
  parameter int          CLK_PER_BIT = 868,
  parameter int          FIFO_AW     = 4,
  parameter logic [31:0] BASE_ADDR   = 32'hFFFF0000
) (
  input  logic          clk,
  input  logic          rst,
  mmio_uart_tx_if.slave bus,
  output logic          txd,
  output logic          overflow
);
  localparam int              DEPTH     = 1 << FIFO_AW;
  localparam int              CW        = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam logic [31:0]     STAT_ADDR = BASE_ADDR + 32'd4;
  localparam logic [CW-1:0]   BAUD_MAX  = CW'(CLK_PER_BIT - 1);
  localparam logic [FIFO_AW:0] DEPTH_C  = (FIFO_AW + 1)'(DEPTH);
`ifdef MMIO_UART_TX_PARITY_EN
  localparam logic PAR_MODE = 1'b1;
`else
  localparam logic PAR_MODE = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t             state, state_n;
  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wptr, rptr;
  logic [FIFO_AW:0]   count;
  logic [7:0]         shreg;
  logic [2:0]         bit_idx;
  logic [CW-1:0]      baud;
  logic               sel_data, sel_stat, full, empty, busy, baud_done, push, pop;
  logic               unused_wdata;

  assign unused_wdata = ^bus.wdata[31:8];
  assign sel_data     = (bus.addr == BASE_ADDR);
  assign sel_stat     = (bus.addr == STAT_ADDR);
  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign busy         = (state != IDLE);
  assign baud_done    = (baud == BAUD_MAX);
  // A pop on the same edge frees a slot, so a store into a full FIFO is still taken.
  assign push         = bus.we && sel_data && (!full || pop);

  always_comb begin
    bus.hit   = sel_data | sel_stat;
    bus.rdata = '0;
    if (sel_stat) bus.rdata = {27'd0, PAR_MODE, overflow, busy, empty, full};
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    case (state)
      IDLE:  if (!empty) begin
               state_n = START;
               pop     = 1'b1;
             end
      START: if (baud_done) state_n = DATA;
`ifdef MMIO_UART_TX_PARITY_EN
      DATA:   if (baud_done && bit_idx == 3'd7) state_n = PARITY;
      PARITY: if (baud_done) state_n = STOP;
`else
      DATA:   if (baud_done && bit_idx == 3'd7) state_n = STOP;
`endif
      STOP:  if (baud_done) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= bus.wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
      txd      <= 1'b1;
      baud     <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop) begin
        rptr  <= rptr + 1'b1;
        shreg <= mem[rptr];
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (bus.we && sel_stat)                overflow <= 1'b0;
      else if (bus.we && sel_data && !push)  overflow <= 1'b1;

      baud <= (state == IDLE || baud_done) ? '0 : baud + 1'b1;

      if (state == IDLE)                  bit_idx <= '0;
      else if (state == DATA && baud_done) bit_idx <= bit_idx + 1'b1;

      // txd follows the current state, so the line lags the FSM by one cycle.
      case (state)
        START:   txd <= 1'b0;
        DATA:    txd <= shreg[bit_idx];
`ifdef MMIO_UART_TX_PARITY_EN
        PARITY:  txd <= ^shreg;
`endif
        default: txd <= 1'b1;
      endcase
    end
  end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Randomized bench for mmio_uart_tx; a queue/arithmetic model predicts txd,
// overflow and status every cycle.
module tb_mmio_uart_tx;
  localparam int          CPB   = 4;
  localparam int          AW    = 4;
  localparam int          DEPTH = 1 << AW;
  localparam logic [31:0] BASE  = 32'hFFFF0000;
  localparam logic [31:0] STAT  = BASE + 32'd4;
`ifdef MMIO_UART_TX_PARITY_EN
  localparam int   FRAME = 11;
  localparam logic PAR   = 1'b1;
`else
  localparam int   FRAME = 10;
  localparam logic PAR   = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic txd, overflow;
  mmio_uart_tx_if bus();

  mmio_uart_tx #(.CLK_PER_BIT(CPB), .FIFO_AW(AW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .bus(bus), .txd(txd), .overflow(overflow));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: byte queue plus frame timing by arithmetic.
  logic [7:0] q[$];
  int         m     = 0;   // index of the most recent rising edge
  int         ret   = 0;   // first edge at which the transmitter is idle again
  int         pop_e = 0;
  bit         fv    = 0;
  bit         ovf   = 0;
  logic [7:0] fbyte = '0;
  bit         chk_en = 0;

  always @(posedge clk) begin
    m = m + 1;
    if (rst) begin
      q.delete();
      ret = 0; ovf = 0; fv = 0;
    end else begin
      if (m >= ret && q.size() > 0) begin
        fbyte = q.pop_front();
        fv    = 1;
        pop_e = m;
        ret   = m + FRAME * CPB + 1;
      end
      if (bus.we && bus.addr == BASE) begin
        if (q.size() < DEPTH) q.push_back(bus.wdata[7:0]);
        else                  ovf = 1;
      end
      if (bus.we && bus.addr == STAT) ovf = 0;
    end
  end

  function automatic logic exp_txd();
    int k;
    if (!fv || m < pop_e + 1 || m >= pop_e + 1 + FRAME * CPB) return 1'b1;
    k = (m - pop_e - 1) / CPB;
    if (k == 0) return 1'b0;
    if (k <= 8) return fbyte[k-1];
    if (k == 9 && PAR) return ^fbyte;
    return 1'b1;
  endfunction

  function automatic logic [31:0] exp_stat();
    return {27'd0, PAR, ovf, (m + 1 < ret), (q.size() == 0), (q.size() == DEPTH)};
  endfunction

  always @(negedge clk) begin
    #1;
    if (chk_en) begin
      chk("txd", txd, exp_txd());
      chk("overflow", overflow, ovf);
      chk("hit", bus.hit, (bus.addr == BASE || bus.addr == STAT));
      chk("rdata", bus.rdata, (bus.addr == STAT) ? exp_stat() : 32'd0);
    end
  end

  task automatic cyc(input bit w, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.we = w; bus.addr = a; bus.wdata = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, STAT, 32'd0);
  endtask

  int n;

  initial begin
    rst = 1'b1; bus.we = 1'b0; bus.addr = STAT; bus.wdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_en = 1;
    idle(20);
    #1 chk("rst_status", bus.rdata, 32'h2 | {27'd0, PAR, 4'd0});
    chk("rst_txd", txd, 1'b1);

    // Single frame
    cyc(1, BASE, 32'h12345655);
    idle(3);
    #1 chk("start_low", txd, 1'b0);
    chk("busy", bus.rdata[2], 1'b1);
    idle(FRAME * CPB + 5);

    // 17 back-to-back stores, then one that must overflow
    for (int i = 0; i <= 16; i++) cyc(1, BASE, i);
    cyc(0, STAT, 0);
    #1 chk("full17", bus.rdata[0], 1'b1);
    cyc(1, BASE, 32'hEE);
    cyc(0, STAT, 0);
    #1 chk("ovf_set", overflow, 1'b1);
    idle(17 * (FRAME * CPB + 1) + 10);
    cyc(1, STAT, 0);
    cyc(0, STAT, 0);
    #1 chk("ovf_clr", overflow, 1'b0);

    // Store on the same edge the FSM pops from a full FIFO
    for (int i = 0; i <= 16; i++) cyc(1, BASE, 8'h40 + i);
    n = 0;
    while (ret != m + 2 && n < 1000) begin cyc(0, STAT, 0); n++; end
    chk("coinc_wait", (ret == m + 2), 1'b1);
    cyc(1, BASE, 32'h5A);
    cyc(0, STAT, 0);
    #1 chk("coinc_full", bus.rdata[0], 1'b1);
    chk("coinc_ovf", overflow, 1'b0);
    idle(17 * (FRAME * CPB + 1) + 10);

    // Reset during DATA bit 3
    cyc(1, BASE, 32'hC3);
    n = 0;
    while (m != pop_e + 1 + 4 * CPB && n < 200) begin cyc(0, STAT, 0); n++; end
    chk("bit3_wait", (m == pop_e + 1 + 4 * CPB), 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rst_mid_txd", txd, 1'b1);
    chk("rst_mid_stat", bus.rdata, 32'h2 | {27'd0, PAR, 4'd0});
    idle(60);

    // Parity-relevant bytes
    cyc(1, BASE, 32'h07);
    idle(FRAME * CPB + 4);
    cyc(1, BASE, 32'h03);
    idle(FRAME * CPB + 4);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      int r;
      logic [31:0] a;
      r = $urandom_range(0, 9);
      a = (r < 5) ? BASE : (r < 7) ? STAT : (r == 7) ? BASE + 32'd8 : $urandom;
      rst = ($urandom_range(0, 499) == 0);
      cyc(($urandom_range(0, 3) == 0), a, $urandom);
    end
    rst = 1'b0;
    idle(DEPTH * (FRAME * CPB + 1) + 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
